pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 157 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a 2-entry skid buffer, flush-to-bubble and a
// saturating bubble counter.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   flush                 discard held entries; output is a bubble next cycle
//   in_valid / in_ready   upstream handshake; in_ready is registered
//   in_ctrl/data/regs     incoming control bundle, data words, reg specifiers
//   out_valid / out_ready downstream handshake
//   out_ctrl/data/regs    registered outputs, driven straight from the main register
//   cnt_clear             synchronous clear of bubble_cnt
//   bubble_cnt            saturating count of edges with out_valid=0
module pipe_stage_skid #(
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_DATA   = 3,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned NUM_REG    = 3,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0]  in_data,
  input  logic [NUM_REG*REG_W-1:0]    in_regs,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0]  out_data,
  output logic [NUM_REG*REG_W-1:0]    out_regs,
  input  logic                        cnt_clear,
  output logic [CNT_W-1:0]            bubble_cnt
);

  localparam int unsigned DW = NUM_DATA * DATA_W;
  localparam int unsigned RW = NUM_REG * REG_W;

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DW-1:0]     main_data_q, main_data_d;
  logic [RW-1:0]     main_regs_q, main_regs_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DW-1:0]     skid_data_q, skid_data_d;
  logic [RW-1:0]     skid_regs_q, skid_regs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic in_hs;
  logic out_hs;

  // Input acceptance depends only on registered skid state, so out_ready has
  // no combinational path to in_ready. A flush drops the incoming entry.
  assign in_hs  = in_valid & ~skid_valid_q & ~flush;
  assign out_hs = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    main_regs_d  = main_regs_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    skid_regs_d  = skid_regs_q;

    if (flush) begin
      // Any output handshake this cycle still consumes main; the stage ends empty.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        main_regs_d = '0;
        skid_data_d = '0;
        skid_regs_d = '0;
      end
    end else if (!main_valid_q) begin
      // Skid is never occupied while main is empty.
      if (in_hs) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
        main_regs_d  = in_regs;
      end
    end else if (out_hs) begin
      if (skid_valid_q) begin
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        main_regs_d  = skid_regs_q;
        skid_valid_d = 1'b0;
      end else if (in_hs) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
        main_regs_d = in_regs;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
        if (CLEAR_DATA) begin
          main_data_d = '0;
          main_regs_d = '0;
        end
      end
    end else if (in_hs) begin
      // Main is stalled: park the new entry in skid.
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
      skid_regs_d  = in_regs;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (!main_valid_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      main_regs_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_regs_q  <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      main_regs_q  <= main_regs_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_regs_q  <= skid_regs_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready   = ~skid_valid_q;
  assign out_valid  = main_valid_q;
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign out_regs   = main_regs_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a queue of accepted entries is the
// reference model; a monitor compares the DUT outputs against it every cycle.
module tb_pipe_stage_skid;

  localparam int CTRL_W   = 8;
  localparam int DATA_W   = 32;
  localparam int NUM_DATA = 3;
  localparam int REG_W    = 5;
  localparam int NUM_REG  = 3;
  localparam int CNT_W    = 16;
  localparam int DW       = NUM_DATA * DATA_W;
  localparam int RW       = NUM_REG * REG_W;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main DUT: default parameters.
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready, cnt_clear;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0]     in_data, out_data;
  logic [RW-1:0]     in_regs, out_regs;
  logic [CNT_W-1:0]  bubble_cnt;

  pipe_stage_skid dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .in_regs    (in_regs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .out_regs   (out_regs),
    .cnt_clear  (cnt_clear),
    .bubble_cnt (bubble_cnt)
  );

  // Second DUT: data held on bubbles, narrow counter.
  logic              b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic              b_cnt_clear;
  logic [CTRL_W-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0]     b_in_data, b_out_data;
  logic [RW-1:0]     b_in_regs, b_out_regs;
  logic [3:0]        b_bubble_cnt;

  pipe_stage_skid #(
    .CLEAR_DATA (1'b0),
    .CNT_W      (4)
  ) dut_b (
    .clock      (clock),
    .reset      (b_reset),
    .flush      (b_flush),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_ctrl    (b_in_ctrl),
    .in_data    (b_in_data),
    .in_regs    (b_in_regs),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_ctrl   (b_out_ctrl),
    .out_data   (b_out_data),
    .out_regs   (b_out_regs),
    .cnt_clear  (b_cnt_clear),
    .bubble_cnt (b_bubble_cnt)
  );

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     data;
    logic [RW-1:0]     regs;
  } entry_t;

  entry_t           sb[$];
  int               errors = 0;
  int               checks = 0;
  bit               mon_en = 1'b0;
  logic [CNT_W-1:0] exp_cnt = '0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: model occupancy is the number of accepted, not yet consumed entries.
  always @(negedge clock) begin : monitor
    int     occ;
    entry_t e;
    if (mon_en) begin
      occ = sb.size();
      check("out_valid", out_valid, occ > 0);
      check("in_ready", in_ready, occ < 2);
      check("bubble_cnt", bubble_cnt, exp_cnt);
      if (occ > 0) begin
        e = sb[0];
        check("out_ctrl", out_ctrl, e.ctrl);
        check("out_data", out_data, e.data);
        check("out_regs", out_regs, e.regs);
        if (out_ready) e = sb.pop_front();
      end else begin
        check("bubble_ctrl", out_ctrl, '0);
        check("bubble_data", out_data, '0);
        check("bubble_regs", out_regs, '0);
      end
      if (cnt_clear) exp_cnt = '0;
      else if (occ == 0 && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    end
  end

  // One cycle of stimulus; the accepted entry is pushed once it is committed.
  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic ordy,
                       input logic fl, input logic clr);
    bit     acc;
    entry_t e;
    @(posedge clock);
    #1;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = {$urandom, $urandom, $urandom};
    in_regs   = RW'($urandom);
    out_ready = ordy;
    flush     = fl;
    cnt_clear = clr;
    acc       = v && (sb.size() < 2) && !fl;
    e.ctrl    = c;
    e.data    = in_data;
    e.regs    = in_regs;
    @(negedge clock);
    #1;
    if (fl) sb.delete();
    else if (acc) sb.push_back(e);
  endtask

  task automatic do_reset(input int n, input logic fl);
    mon_en = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    flush = fl;
    repeat (n - 1) @(posedge clock);
    @(posedge clock);
    #1;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clear = 1'b0;
    sb.delete();
    exp_cnt   = '0;
    mon_en    = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0;
    in_ctrl = '0; in_data = '0; in_regs = '0;
    b_reset = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_cnt_clear = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_in_regs = '0;

    do_reset(2, 1'b0);

    // Streaming at full throughput.
    drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Back-pressure fills skid, then drains.
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush with full skid; 3C offered in the flush cycle must vanish.
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush together with a downstream accept.
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, CTRL_W'($urandom), $urandom_range(0, 9) < 7,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
    end

    // Reset in the middle of traffic, with skid full and flush asserted.
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    do_reset(1, 1'b1);
    repeat (4) drive(1'b1, CTRL_W'($urandom), 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Second build: counter saturation and data hold on flush.
    @(posedge clock);
    #1;
    b_reset = 1'b1;
    repeat (14) @(posedge clock);
    #1;
    check("b_cnt_14", b_bubble_cnt, 4'd14);
    repeat (6) @(posedge clock);
    #1;
    check("b_cnt_sat", b_bubble_cnt, 4'd15);
    b_cnt_clear = 1'b1;
    @(posedge clock);
    #1;
    b_cnt_clear = 1'b0;
    check("b_cnt_clear", b_bubble_cnt, 4'd0);
    b_in_valid  = 1'b1;
    b_in_ctrl   = 8'hC3;
    b_in_data   = {64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF};
    b_in_regs   = 15'h1234;
    b_out_ready = 1'b0;
    @(posedge clock);
    #1;
    b_in_valid = 1'b0;
    check("b_load_valid", b_out_valid, 1'b1);
    check("b_load_ctrl", b_out_ctrl, 8'hC3);
    check("b_load_word0", b_out_data[31:0], 32'hDEAD_BEEF);
    b_flush = 1'b1;
    @(posedge clock);
    #1;
    b_flush = 1'b0;
    check("b_flush_valid", b_out_valid, 1'b0);
    check("b_flush_ctrl", b_out_ctrl, 8'h00);
    check("b_flush_word0", b_out_data[31:0], 32'hDEAD_BEEF);
    check("b_flush_regs", b_out_regs, 15'h1234);
    check("b_flush_ready", b_in_ready, 1'b1);

    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
